// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared mode encodings and one-hot helper for the scan decoder
//
// Contents:
//   MODE_DIRECT / MODE_SCAN : values of the decoder's mode input
//   OH_MAX_W                : widest one-hot vector onehot() can build
//   onehot(code, n)         : OH_MAX_W-bit vector with bit `code` set, zero when code >= n
package dec_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int unsigned OH_MAX_W = 256;

  // Callers narrow the result to their own output width with a size cast.
  function automatic logic [OH_MAX_W-1:0] onehot(input int unsigned code, input int unsigned n);
    logic [OH_MAX_W-1:0] result;
    if (code < n && code < OH_MAX_W) begin
      result = OH_MAX_W'(1) << code;
    end else begin
      result = '0;
    end
    return result;
  endfunction

endpackage

// File: rtl/dec_dwell_tick.sv
// rtl/dec_dwell_tick.sv - dwell counter producing a terminal-count tick for the scan decoder
//
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset, clears the count
//   run   in  count one step this cycle
//   clear in  restart the dwell at zero; wins over run and suppresses tick
//   tick  out high during the cycle whose edge completes a DWELL-long dwell
module dec_dwell_tick #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] TERM = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  // Combinational so the owner can advance on the same edge that wraps the count.
  assign tick = run && !clear && (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == TERM) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dec_scan_mton.sv
// rtl/dec_scan_mton.sv - registered M-to-N one-hot decoder with direct and auto-scan modes
//
// Optional feature macro: DEC_OOR_ERR_EN (adds sticky out-of-range load flag `err`)
//
// Ports:
//   clk   in  system clock, rising edge
//   rst_n in  asynchronous active-low reset
//   _en   in  active-low enable; high blanks dout/wrap and freezes idx and dwell
//   mode  in  MODE_DIRECT (hold loaded code) or MODE_SCAN (step idx every DWELL cycles)
//   load  in  one-cycle strobe capturing din into idx
//   din   in  code to decode, or scan start index
//   dout  out registered one-hot of idx, zero when disabled or idx >= N
//   idx   out current index register
//   wrap  out one-cycle pulse when a scan steps idx from N-1 to 0
//   err   out (DEC_OOR_ERR_EN only) sticky, set after an enabled load with din >= N
module dec_scan_mton
  import dec_pkg::*;
#(
  parameter int M     = 3,
  parameter int N     = 8,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         _en,
  input  logic         mode,
  input  logic         load,
  input  logic [M-1:0] din,
  output logic [N-1:0] dout,
  output logic [M-1:0] idx,
  output logic         wrap
`ifdef DEC_OOR_ERR_EN
  ,
  output logic         err
`endif
);

  localparam logic [M-1:0] LAST = M'(N - 1);

  logic         enabled;
  logic         mode_q;      // mode seen on the last enabled edge
  logic         scan_entry;
  logic         dwell_run;
  logic         dwell_clear;
  logic         tick;
  logic [M-1:0] idx_next;
  logic         wrap_next;
  logic [N-1:0] dout_next;

  assign enabled = !_en;

  // Entering SCAN restarts the dwell so the first step lands a full DWELL after the switch.
  assign scan_entry  = enabled && (mode == MODE_SCAN) && (mode_q == MODE_DIRECT);
  assign dwell_run   = enabled && (mode == MODE_SCAN);
  assign dwell_clear = enabled && (load || scan_entry);

  dec_dwell_tick #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (dwell_run),
    .clear(dwell_clear),
    .tick (tick)
  );

  always_comb begin
    idx_next  = idx;
    wrap_next = 1'b0;
    if (enabled) begin
      if (load) begin
        idx_next = din;
      end else if (tick) begin
        // Index arithmetic is modulo N; an out-of-range index recovers to 0 silently.
        if (idx == LAST) begin
          idx_next  = '0;
          wrap_next = 1'b1;
        end else if (idx > LAST) begin
          idx_next = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    dout_next = '0;
    if (enabled) begin
      dout_next = N'(onehot(32'(idx_next), N));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      idx    <= '0;
      wrap   <= 1'b0;
      mode_q <= MODE_DIRECT;
    end else begin
      dout <= dout_next;
      wrap <= wrap_next;
      idx  <= idx_next;
      if (enabled) begin
        mode_q <= mode;
      end
    end
  end

`ifdef DEC_OOR_ERR_EN
  logic din_oor;

  assign din_oor = 32'(din) >= 32'(N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (enabled && load && din_oor) begin
      err <= 1'b1;
    end
  end
`else
  // Out-of-range loads leave no status behind; onehot() already blanks dout for them.
`endif

endmodule

// File: tb/tb_dec_scan_mton.sv
// tb/tb_dec_scan_mton.sv - self-checking bench for dec_scan_mton
module tb_dec_scan_mton;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic       a_en_n, a_mode, a_load;
  logic [2:0] a_din;
  logic [7:0] a_dout;
  logic [2:0] a_idx;
  logic       a_wrap;

  logic       b_en_n, b_mode, b_load;
  logic [2:0] b_din;
  logic [5:0] b_dout;
  logic [2:0] b_idx;
  logic       b_wrap;

  logic       c_en_n, c_mode, c_load;
  logic [1:0] c_din;
  logic [2:0] c_dout;
  logic [1:0] c_idx;
  logic       c_wrap;

`ifdef DEC_OOR_ERR_EN
  logic a_err, b_err, c_err;
`endif

  dec_scan_mton #(.M(3), .N(8), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), ._en(a_en_n), .mode(a_mode), .load(a_load), .din(a_din),
    .dout(a_dout), .idx(a_idx), .wrap(a_wrap)
`ifdef DEC_OOR_ERR_EN
    , .err(a_err)
`endif
  );

  dec_scan_mton #(.M(3), .N(6), .DWELL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), ._en(b_en_n), .mode(b_mode), .load(b_load), .din(b_din),
    .dout(b_dout), .idx(b_idx), .wrap(b_wrap)
`ifdef DEC_OOR_ERR_EN
    , .err(b_err)
`endif
  );

  dec_scan_mton #(.M(2), .N(3), .DWELL(1)) dut_c (
    .clk(clk), .rst_n(rst_n), ._en(c_en_n), .mode(c_mode), .load(c_load), .din(c_din),
    .dout(c_dout), .idx(c_idx), .wrap(c_wrap)
`ifdef DEC_OOR_ERR_EN
    , .err(c_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: idx position, enabled scan cycles spent at the current position,
  // and whether the previous enabled cycle was already scanning.
  typedef struct {
    int idx;
    int spent;
    bit was_scanning;
    int dout;
    bit wrap;
    bit err;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.idx = 0; r.spent = 0; r.was_scanning = 0; r.dout = 0; r.wrap = 0; r.err = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, bit en_n, bit mode, bit load, int din, int n, int dwell);
    mdl_t r = s;
    r.wrap = 0;
    if (en_n) begin
      r.dout = 0;
      return r;
    end
    if (load) begin
      r.idx = din;
      r.spent = 0;
      if (din >= n) r.err = 1;
    end else if (mode) begin
      if (!s.was_scanning) begin
        r.spent = 0;
      end else begin
        r.spent = r.spent + 1;
        if (r.spent == dwell) begin
          r.spent = 0;
          r.wrap = (r.idx == n - 1);
          r.idx = (r.idx + 1 >= n) ? 0 : r.idx + 1;
        end
      end
    end
    r.was_scanning = mode;
    r.dout = (r.idx < n) ? (1 << r.idx) : 0;
    return r;
  endfunction

  typedef struct {
    bit       en_n;
    bit       mode;
    bit       load;
    bit [2:0] din;
    bit [7:0] dout;
    bit [2:0] idx;
    bit       wrap;
  } vec_t;

  vec_t vecs[27];

  task automatic tick_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit en_n, input bit mode, input bit load, input bit [2:0] din);
    a_en_n = en_n; a_mode = mode; a_load = load; a_din = din;
  endtask

  task automatic set_b(input bit en_n, input bit mode, input bit load, input bit [2:0] din);
    b_en_n = en_n; b_mode = mode; b_load = load; b_din = din;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  mdl_t ma, mb, mc;

  initial begin
    set_a(1, 0, 0, 0);
    set_b(1, 0, 0, 0);
    c_en_n = 1; c_mode = 0; c_load = 0; c_din = 0;

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 3'd5, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h20, 3'd5, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 3'd3, 8'h20, 3'd5, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 3'd2, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h04, 3'd2, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h04, 3'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h04, 3'd2, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h04, 3'd2, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h08, 3'd3, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h08, 3'd3, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h08, 3'd3, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 3'd6, 8'h40, 3'd6, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h40, 3'd6, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h40, 3'd6, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h40, 3'd6, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h80, 3'd7, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h80, 3'd7, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h80, 3'd7, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h80, 3'd7, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b1, 3'd4, 8'h00, 3'd0, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b0};
    vecs[26] = '{1'b0, 1'b1, 1'b0, 3'd0, 8'h02, 3'd1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_dout", a_dout, 0);
    chk("rst_a_idx", a_idx, 0);
    chk("rst_a_wrap", a_wrap, 0);
    chk("rst_b_dout", b_dout, 0);
    chk("rst_c_dout", c_dout, 0);
    rst_n = 1'b1;

    // Directed table on the 3-to-8, DWELL=4 instance.
    for (int i = 0; i < 27; i++) begin
      set_a(vecs[i].en_n, vecs[i].mode, vecs[i].load, vecs[i].din);
      tick_sample();
      chk($sformatf("vec%0d_dout", i), a_dout, vecs[i].dout);
      chk($sformatf("vec%0d_idx", i), a_idx, vecs[i].idx);
      chk($sformatf("vec%0d_wrap", i), a_wrap, vecs[i].wrap);
    end

    // Asynchronous reset mid-dwell at idx=3: outputs clear with no clock edge.
    set_a(0, 1, 1, 3);
    tick_sample();
    set_a(0, 1, 0, 0);
    tick_sample();
    chk("pre_rst_idx", a_idx, 3);
    chk("pre_rst_dout", a_dout, 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout", a_dout, 0);
    chk("async_rst_idx", a_idx, 0);
    chk("async_rst_wrap", a_wrap, 0);
    rst_n = 1'b1;

    // Asynchronous reset while wrap is high.
    set_a(0, 1, 1, 7);
    tick_sample();
    set_a(0, 1, 0, 0);
    repeat (4) tick_sample();
    chk("wrap_before_rst", a_wrap, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wrap_hi", a_wrap, 0);
    rst_n = 1'b1;
    set_a(1, 0, 0, 0);

    // 3-to-6 instance, DWELL=2: out-of-range load, recovery to 0 without wrap.
    set_b(0, 1, 1, 7);
    tick_sample();
    chk("oor_dout", b_dout, 0);
    chk("oor_idx", b_idx, 7);
`ifdef DEC_OOR_ERR_EN
    chk("oor_err", b_err, 1);
`endif
    set_b(0, 1, 0, 0);
    tick_sample();
    chk("oor_hold_idx", b_idx, 7);
    tick_sample();
    chk("oor_recover_idx", b_idx, 0);
    chk("oor_recover_dout", b_dout, 1);
    chk("oor_recover_wrap", b_wrap, 0);
`ifdef DEC_OOR_ERR_EN
    chk("oor_err_sticky", b_err, 1);
`endif
    set_b(0, 1, 1, 5);
    tick_sample();
    chk("b_last_dout", b_dout, 6'h20);
    set_b(0, 1, 0, 0);
    tick_sample();
    chk("b_last_wrap0", b_wrap, 0);
    tick_sample();
    chk("b_wrap_idx", b_idx, 0);
    chk("b_wrap_pulse", b_wrap, 1);
    tick_sample();
    chk("b_wrap_drop", b_wrap, 0);

    // Randomized run of all three instances against the model.
    do_reset();
    ma = mdl_reset();
    mb = mdl_reset();
    mc = mdl_reset();
    begin
      bit en_n = 0, mode = 0, load;
      int din;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset();
          ma = mdl_reset();
          mb = mdl_reset();
          mc = mdl_reset();
          chk("rand_rst_a_dout", a_dout, 0);
          chk("rand_rst_b_idx", b_idx, 0);
        end
        en_n = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 19) == 0) mode = !mode;
        load = ($urandom_range(0, 7) == 0);
        din = $urandom_range(0, 7);
        set_a(en_n, mode, load, 3'(din));
        set_b(en_n, mode, load, 3'(din));
        c_en_n = en_n; c_mode = mode; c_load = load; c_din = 2'(din);
        tick_sample();
        ma = mdl_step(ma, en_n, mode, load, din, 8, 4);
        mb = mdl_step(mb, en_n, mode, load, din, 6, 2);
        mc = mdl_step(mc, en_n, mode, load, din % 4, 3, 1);
        chk("rand_a_dout", a_dout, ma.dout);
        chk("rand_a_idx", a_idx, ma.idx);
        chk("rand_a_wrap", a_wrap, ma.wrap);
        chk("rand_b_dout", b_dout, mb.dout);
        chk("rand_b_idx", b_idx, mb.idx);
        chk("rand_b_wrap", b_wrap, mb.wrap);
        chk("rand_c_dout", c_dout, mc.dout);
        chk("rand_c_idx", c_idx, mc.idx);
        chk("rand_c_wrap", c_wrap, mc.wrap);
`ifdef DEC_OOR_ERR_EN
        chk("rand_b_err", b_err, mb.err);
        chk("rand_c_err", c_err, mc.err);
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_scan_mton.md
Name: dec_scan_mton

Overview:
- Registered, parametrised M-to-N one-hot decoder with active-low enable.
- Two modes:
  - DIRECT: latches a loaded code and drives its one-hot.
  - SCAN: auto-steps the one-hot output through 0..N-1 at a programmable dwell rate, e.g. for display-digit or row strobing.
- Sits between control logic and multiplexed output drivers in lab designs.

Parameters:
- M, 3, input code width.
- N, 8, output width; legal range 2 <= N <= 2**M.
- DWELL, 4, clock cycles each index is held in SCAN mode; legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- _en  input  1  active-low enable; 1 blanks the outputs and freezes state.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- load  input  1  one-cycle strobe; captures din.
- din  input  M  code to decode or scan start index.
- dout  output  N  registered one-hot output.
- idx  output  M  current index register.
- wrap  output  1  one-cycle pulse in SCAN when idx wraps from N-1 to 0.

Behaviour:
- Reset (rst_n=0, asynchronous): dout=0, idx=0, wrap=0, dwell counter=0.
- Reset takes effect immediately, mid-scan or mid-load.
- All outputs are registered.
- Output latency: 1 cycle from the sampling edge. dout always equals onehot(idx) when enabled and idx<N; otherwise dout=0.
- _en=1:
  - Next edge: dout=0, wrap=0.
  - idx and dwell counter hold.
  - load is ignored.
- _en=0, mode=DIRECT:
  - load=1: idx<=din; dout<=onehot(din) if din<N, else 0.
  - load=0: everything holds.
  - Dwell counter is held at 0.
- _en=0, mode=SCAN:
  - Dwell counter counts 0..DWELL-1.
  - At terminal count, idx advances by 1. If idx==N-1, idx<=0 and wrap pulses 1 for exactly that cycle.
  - load=1 overrides advance: idx<=din, dwell counter<=0, no wrap.
  - Loading din>=N: idx<=din, dout=0. At the next terminal count idx<=0 with no wrap pulse.
- Mode change DIRECT->SCAN: scanning starts from the current idx with the dwell counter cleared. The first advance occurs DWELL cycles later.
- Mode change SCAN->DIRECT: idx and dout freeze at their current value.
- Enable release (_en 1->0): dout restored to onehot(idx) on the next edge. Dwell resumes from its held count.
- DWELL=1: idx advances every enabled cycle.
- Width rule: the dwell counter is $clog2(DWELL+1) bits. idx arithmetic is modulo N, never 2**M.

Optional Feature:
- Macro: DEC_OOR_ERR_EN.
- Defined:
  - Adds output port err (1 bit). err is a sticky flag, set on the cycle after any load with din>=N while _en=0.
  - Cleared only by rst_n.
- Undefined: port err absent; out-of-range loads silently blank dout as above.

Decomposition:
- Package dec_pkg holds:
  - localparam MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
  - Function onehot(code, N) returning the N-bit vector, zero when code>=N.
- One sub-module, dec_dwell_tick:
  - Parametrised by DWELL.
  - Inputs: clk, rst_n, run, clear.
  - Output: tick, one-cycle high at terminal count.
  - dec_scan_mton instantiates it with run = !_en && mode, clear = load | mode-entry.

Test Plan:
1. Reset then DIRECT, _en=0, load din=5 -> dout=8'b0010_0000 and idx=5 one cycle later; holds with load=0.
2. SCAN, DWELL=4, load din=6 -> dout 0100_0000 for 4 cycles, then 1000_0000 for 4 cycles, then 0000_0001 with wrap=1 for exactly one cycle.
3. SCAN, _en=1 for 3 cycles mid-dwell -> dout=0, idx frozen; on _en=0 scanning resumes without losing the remaining dwell count.
4. Instantiate M=3, N=6 and load din=7 -> dout=0, err=1 (with DEC_OOR_ERR_EN defined), idx returns to 0 at next terminal count with wrap=0.
5. SCAN at idx=3 with assertion of rst_n low mid-dwell -> immediately dout=0, idx=0, wrap=0, with no clock edge needed.
6. DIRECT at idx=2, switch to SCAN -> dout stays 0000_0100 for DWELL cycles, then 0000_1000; switch back to DIRECT -> frozen.
